// File: rtl/bp_cce_hybrid_pending_release.sv
// Memory-response pass-through for the hybrid CCE. Forwards header and data
// beats unchanged and, for every header that completes a coherent transaction,
// queues the address and issues a pending-bit decrement on the pending write
// port.
//
// Handshakes: a transfer happens on any cycle where valid and ready/ready_and
// are both high at the rising clock edge. On the pending port the producer
// raises pending_w_v_o and holds it, together with the address, until the
// consumer pulses pending_w_yumi_i (valid-then-yumi). Yumi is legal only while
// pending_w_v_o is high.
module bp_cce_hybrid_pending_release #(
   parameter int paddr_width_p  = 40,
   parameter int header_width_p = 128,
   parameter int data_width_p   = 64,
   parameter int release_els_p  = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,

   input  logic [header_width_p-1:0]              mem_rsp_header_i,
   input  logic                                   mem_rsp_header_v_i,
   output logic                                   mem_rsp_header_ready_and_o,
   input  logic                                   mem_rsp_has_data_i,
   input  logic                                   mem_rsp_release_i,
   input  logic [paddr_width_p-1:0]               mem_rsp_addr_i,
   input  logic                                   mem_rsp_bypass_hash_i,
   input  logic [data_width_p-1:0]                mem_rsp_data_i,
   input  logic                                   mem_rsp_data_v_i,
   output logic                                   mem_rsp_data_ready_and_o,
   input  logic                                   mem_rsp_last_i,

   output logic [header_width_p-1:0]              mem_rsp_header_o,
   output logic                                   mem_rsp_header_v_o,
   input  logic                                   mem_rsp_header_ready_and_i,
   output logic                                   mem_rsp_has_data_o,
   output logic [data_width_p-1:0]                mem_rsp_data_o,
   output logic                                   mem_rsp_data_v_o,
   input  logic                                   mem_rsp_data_ready_and_i,
   output logic                                   mem_rsp_last_o,

   output logic                                   pending_w_v_o,
   input  logic                                   pending_w_yumi_i,
   output logic [paddr_width_p-1:0]               pending_w_addr_o,
   output logic                                   pending_w_addr_bypass_hash_o,
   output logic                                   pending_up_o,
   output logic                                   pending_down_o,
   output logic                                   pending_clear_o,

   output logic                                   empty_o,
   output logic [$clog2(release_els_p+1)-1:0]     count_o,

   // Stream FSM state for observation: 0 = e_ready, 1 = e_data
   output logic                                   dbg_state_o
);

   localparam int ptr_w_lp = $clog2(release_els_p);
   localparam int cnt_w_lp = $clog2(release_els_p+1);

   typedef enum logic {e_ready = 1'b0, e_data = 1'b1} state_e;

   state_e                    r_state;
   logic [paddr_width_p-1:0]  r_addr_mem [release_els_p];
   logic                      r_bh_mem   [release_els_p];
   logic [ptr_w_lp-1:0]       r_rptr;
   logic [ptr_w_lp-1:0]       r_wptr;
   logic [cnt_w_lp-1:0]       r_count;

   logic w_empty, w_full, w_ok;
   logic w_in_ready, w_in_data;
   logic w_hdr_acc, w_last_acc, w_enq, w_deq;

   // Occupancy flags; full never looks at yumi so header ready has no path
   // from the pending-port consumer.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == cnt_w_lp'(release_els_p));
   assign w_ok    = ~mem_rsp_release_i | ~w_full;

   // Gating with reset_n_i forces every valid/ready low as soon as reset hits.
   assign w_in_ready = reset_n_i & (r_state == e_ready);
   assign w_in_data  = reset_n_i & (r_state == e_data);

   assign mem_rsp_header_o           = mem_rsp_header_i;
   assign mem_rsp_has_data_o         = mem_rsp_has_data_i;
   assign mem_rsp_header_v_o         = w_in_ready & mem_rsp_header_v_i & w_ok;
   assign mem_rsp_header_ready_and_o = w_in_ready & mem_rsp_header_ready_and_i & w_ok;

   assign mem_rsp_data_o             = w_in_data ? mem_rsp_data_i : '0;
   assign mem_rsp_data_v_o           = w_in_data & mem_rsp_data_v_i;
   assign mem_rsp_data_ready_and_o   = w_in_data & mem_rsp_data_ready_and_i;
   assign mem_rsp_last_o             = w_in_data & mem_rsp_last_i;

   assign w_hdr_acc  = mem_rsp_header_v_i & mem_rsp_header_ready_and_o;
   assign w_last_acc = mem_rsp_data_v_i & mem_rsp_data_ready_and_o & mem_rsp_last_i;
   assign w_enq      = w_hdr_acc & mem_rsp_release_i;
   assign w_deq      = pending_w_yumi_i & ~w_empty;

   assign pending_w_v_o                = ~w_empty;
   assign pending_w_addr_o             = r_addr_mem[r_rptr];
   assign pending_w_addr_bypass_hash_o = r_bh_mem[r_rptr];
   assign pending_down_o               = ~w_empty;
   assign pending_up_o                 = 1'b0;
   assign pending_clear_o              = 1'b0;

   assign empty_o     = w_empty;
   assign count_o     = r_count;
   assign dbg_state_o = r_state;

   // Stream FSM: a header with data moves to e_data until the last beat.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= e_ready;
      end else begin
         case (r_state)
            e_ready: if (w_hdr_acc && mem_rsp_has_data_i) r_state <= e_data;
            e_data:  if (w_last_acc)                      r_state <= e_ready;
            default:                                      r_state <= e_ready;
         endcase
      end
   end

   // Release FIFO pointers and occupancy; pointers wrap naturally (power of 2).
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_wptr <= r_wptr + 1'b1;
         if (w_deq) r_rptr <= r_rptr + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Release FIFO storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_addr_mem[r_wptr] <= mem_rsp_addr_i;
         r_bh_mem[r_wptr]   <= mem_rsp_bypass_hash_i;
      end
   end

   // Protocol checks on the surrounding blocks.
   a_yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      pending_w_yumi_i |-> pending_w_v_o);
   a_data_in_ready: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(r_state == e_ready && mem_rsp_data_v_i));

endmodule

// File: tb/tb_bp_cce_hybrid_pending_release.sv
// Self-checking bench for bp_cce_hybrid_pending_release. Inputs change 1 time
// unit after the rising edge; the monitor samples on the falling edge, where a
// visible valid&ready pair is the transfer taken at the next rising edge.
module tb_bp_cce_hybrid_pending_release;

   localparam int PA = 40;
   localparam int HW = 128;
   localparam int DW = 64;
   localparam int EL = 4;
   localparam int CW = $clog2(EL+1);

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic reset_n_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [HW-1:0] mem_rsp_header_i = '0;
   logic          mem_rsp_header_v_i = 1'b0;
   logic          mem_rsp_header_ready_and_o;
   logic          mem_rsp_has_data_i = 1'b0;
   logic          mem_rsp_release_i = 1'b0;
   logic [PA-1:0] mem_rsp_addr_i = '0;
   logic          mem_rsp_bypass_hash_i = 1'b0;
   logic [DW-1:0] mem_rsp_data_i = '0;
   logic          mem_rsp_data_v_i = 1'b0;
   logic          mem_rsp_data_ready_and_o;
   logic          mem_rsp_last_i = 1'b0;
   logic [HW-1:0] mem_rsp_header_o;
   logic          mem_rsp_header_v_o;
   logic          mem_rsp_header_ready_and_i = 1'b1;
   logic          mem_rsp_has_data_o;
   logic [DW-1:0] mem_rsp_data_o;
   logic          mem_rsp_data_v_o;
   logic          mem_rsp_data_ready_and_i = 1'b1;
   logic          mem_rsp_last_o;
   logic          pending_w_v_o;
   logic          pending_w_yumi_i;
   logic [PA-1:0] pending_w_addr_o;
   logic          pending_w_addr_bypass_hash_o;
   logic          pending_up_o, pending_down_o, pending_clear_o;
   logic          empty_o;
   logic [CW-1:0] count_o;
   logic          dbg_state_o;

   logic yumi_drv = 1'b0;
   logic tie_en   = 1'b0;
   logic tog_en   = 1'b0;
   assign pending_w_yumi_i = tie_en ? pending_w_v_o : yumi_drv;

   bp_cce_hybrid_pending_release #(
      .paddr_width_p(PA), .header_width_p(HW), .data_width_p(DW), .release_els_p(EL)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .mem_rsp_header_i(mem_rsp_header_i), .mem_rsp_header_v_i(mem_rsp_header_v_i),
      .mem_rsp_header_ready_and_o(mem_rsp_header_ready_and_o),
      .mem_rsp_has_data_i(mem_rsp_has_data_i), .mem_rsp_release_i(mem_rsp_release_i),
      .mem_rsp_addr_i(mem_rsp_addr_i), .mem_rsp_bypass_hash_i(mem_rsp_bypass_hash_i),
      .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_data_v_i(mem_rsp_data_v_i),
      .mem_rsp_data_ready_and_o(mem_rsp_data_ready_and_o), .mem_rsp_last_i(mem_rsp_last_i),
      .mem_rsp_header_o(mem_rsp_header_o), .mem_rsp_header_v_o(mem_rsp_header_v_o),
      .mem_rsp_header_ready_and_i(mem_rsp_header_ready_and_i),
      .mem_rsp_has_data_o(mem_rsp_has_data_o),
      .mem_rsp_data_o(mem_rsp_data_o), .mem_rsp_data_v_o(mem_rsp_data_v_o),
      .mem_rsp_data_ready_and_i(mem_rsp_data_ready_and_i), .mem_rsp_last_o(mem_rsp_last_o),
      .pending_w_v_o(pending_w_v_o), .pending_w_yumi_i(pending_w_yumi_i),
      .pending_w_addr_o(pending_w_addr_o),
      .pending_w_addr_bypass_hash_o(pending_w_addr_bypass_hash_o),
      .pending_up_o(pending_up_o), .pending_down_o(pending_down_o),
      .pending_clear_o(pending_clear_o),
      .empty_o(empty_o), .count_o(count_o), .dbg_state_o(dbg_state_o)
   );

   // ---------------- scoreboard ----------------
   logic [HW:0]   hdr_q[$];   // {has_data, header}
   logic [DW:0]   data_q[$];  // {last, data}
   logic [PA:0]   rel_q[$];   // {bypass_hash, addr}
   int checks = 0;
   int errors = 0;
   int rel_pops = 0;

   task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expected queues whenever a transfer is visible.
   initial begin
      logic [HW:0] eh;
      logic [DW:0] ed;
      logic [PA:0] er;
      forever begin
         @(negedge clk_i);
         if (reset_n_i) begin
            if (mem_rsp_header_v_o && mem_rsp_header_ready_and_i) begin
               if (hdr_q.size() == 0) chk("hdr_unexpected", 1, 0);
               else begin
                  eh = hdr_q.pop_front();
                  chk("hdr_o", mem_rsp_header_o, eh[HW-1:0]);
                  chk("hdr_has_data", HW'(mem_rsp_has_data_o), HW'(eh[HW]));
               end
            end
            if (mem_rsp_data_v_o && mem_rsp_data_ready_and_i) begin
               if (data_q.size() == 0) chk("data_unexpected", 1, 0);
               else begin
                  ed = data_q.pop_front();
                  chk("data_o", HW'(mem_rsp_data_o), HW'(ed[DW-1:0]));
                  chk("last_o", HW'(mem_rsp_last_o), HW'(ed[DW]));
               end
            end
            if (pending_w_v_o && pending_w_yumi_i) begin
               rel_pops++;
               if (rel_q.size() == 0) chk("rel_unexpected", 1, 0);
               else begin
                  er = rel_q.pop_front();
                  chk("rel_addr", HW'(pending_w_addr_o), HW'(er[PA-1:0]));
                  chk("rel_bh", HW'(pending_w_addr_bypass_hash_o), HW'(er[PA]));
                  chk("rel_op", HW'({pending_up_o, pending_down_o, pending_clear_o}), HW'(3'b010));
               end
            end
         end
      end
   end

   // Downstream data ready: toggles each cycle when enabled, else held high.
   initial begin
      forever begin
         @(posedge clk_i); #1;
         if (tog_en) mem_rsp_data_ready_and_i = ~mem_rsp_data_ready_and_i;
         else        mem_rsp_data_ready_and_i = 1'b1;
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic offer_hdr(input logic [HW-1:0] h, input logic hd, input logic rel,
                            input logic [PA-1:0] a, input logic bh);
      mem_rsp_header_i      = h;
      mem_rsp_has_data_i    = hd;
      mem_rsp_release_i     = rel;
      mem_rsp_addr_i        = a;
      mem_rsp_bypass_hash_i = bh;
      mem_rsp_header_v_i    = 1'b1;
      hdr_q.push_back({hd, h});
      if (rel) rel_q.push_back({bh, a});
   endtask

   task automatic wait_hdr();
      logic acc = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         if (mem_rsp_header_v_i && mem_rsp_header_ready_and_o) begin
            acc = 1'b1;
            break;
         end
         @(posedge clk_i); #1;
      end
      if (acc) begin
         @(posedge clk_i); #1;
      end
      mem_rsp_header_v_i = 1'b0;
      mem_rsp_release_i  = 1'b0;
      chk("hdr_accept_within_budget", HW'(acc), HW'(1));
   endtask

   task automatic send_hdr(input logic [HW-1:0] h, input logic hd, input logic rel,
                           input logic [PA-1:0] a, input logic bh);
      offer_hdr(h, hd, rel, a, bh);
      wait_hdr();
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic last);
      logic acc = 1'b0;
      data_q.push_back({last, d});
      mem_rsp_data_i   = d;
      mem_rsp_last_i   = last;
      mem_rsp_data_v_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         chk("hdr_blocked_in_data", HW'(mem_rsp_header_ready_and_o | mem_rsp_header_v_o), HW'(0));
         if (mem_rsp_data_v_o && mem_rsp_data_ready_and_i) begin
            acc = 1'b1;
            break;
         end
         @(posedge clk_i); #1;
      end
      if (acc) begin
         @(posedge clk_i); #1;
      end
      mem_rsp_data_v_i = 1'b0;
      mem_rsp_last_i   = 1'b0;
      chk("beat_accept_within_budget", HW'(acc), HW'(1));
   endtask

   function automatic logic [HW-1:0] mk_hdr(input int id);
      return {4{32'hC0DE_0000 + 32'(id)}};
   endfunction

   // ---------------- stimulus ----------------
   logic [PA-1:0] addrs [6] = '{40'h80_0000_1000, 40'h80_0000_2040, 40'h00_1234_5680,
                                40'hFF_FFFF_FFC0, 40'h00_0000_0000, 40'h55_AAAA_5540};
   int base_pops;

   initial begin
      // Reset: outputs quiet even with an upstream header offered.
      mem_rsp_header_v_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_hdr_v_o", HW'(mem_rsp_header_v_o), HW'(0));
      chk("rst_hdr_ready_o", HW'(mem_rsp_header_ready_and_o), HW'(0));
      chk("rst_pending_v", HW'(pending_w_v_o), HW'(0));
      chk("rst_count", HW'(count_o), HW'(0));
      chk("rst_empty", HW'(empty_o), HW'(1));
      chk("rst_state", HW'(dbg_state_o), HW'(0));
      mem_rsp_header_v_i = 1'b0;
      reset_n_i = 1'b1;
      @(posedge clk_i); #1;

      // Single release header: forwarded same cycle, release visible next cycle.
      offer_hdr(mk_hdr(1), 1'b0, 1'b1, 40'h00_8000_0040, 1'b0);
      @(negedge clk_i);
      chk("t1_hdr_fwd_same_cycle", HW'(mem_rsp_header_v_o), HW'(1));
      chk("t1_pending_not_yet", HW'(pending_w_v_o), HW'(0));
      @(posedge clk_i); #1;
      mem_rsp_header_v_i = 1'b0;
      mem_rsp_release_i  = 1'b0;
      chk("t1_pending_v", HW'(pending_w_v_o), HW'(1));
      chk("t1_pending_addr", HW'(pending_w_addr_o), HW'(40'h00_8000_0040));
      chk("t1_down", HW'(pending_down_o), HW'(1));
      chk("t1_up", HW'(pending_up_o), HW'(0));
      yumi_drv = 1'b1;
      @(posedge clk_i); #1;
      yumi_drv = 1'b0;
      chk("t1_empty_after_yumi", HW'(empty_o), HW'(1));

      // Header with 4 data beats, downstream ready toggling; a second header waits.
      send_hdr(mk_hdr(2), 1'b1, 1'b0, '0, 1'b0);
      chk("t2_state_data", HW'(dbg_state_o), HW'(1));
      offer_hdr(mk_hdr(3), 1'b0, 1'b0, '0, 1'b0);
      tog_en = 1'b1;
      send_beat(64'h1111_0000_0000_0001, 1'b0);
      send_beat(64'h2222_0000_0000_0002, 1'b0);
      send_beat(64'h3333_0000_0000_0003, 1'b0);
      send_beat(64'h4444_0000_0000_0004, 1'b1);
      tog_en = 1'b0;
      chk("t2_state_ready", HW'(dbg_state_o), HW'(0));
      wait_hdr();

      // Fill the FIFO with yumi held low.
      for (int i = 0; i < 4; i++) send_hdr(mk_hdr(10+i), 1'b0, 1'b1, addrs[i], 1'(i));
      chk("t3_count_full", HW'(count_o), HW'(4));
      chk("t3_not_empty", HW'(empty_o), HW'(0));
      // A fifth release is blocked (offered without expectation, then withdrawn).
      mem_rsp_header_i   = mk_hdr(99);
      mem_rsp_release_i  = 1'b1;
      mem_rsp_has_data_i = 1'b0;
      mem_rsp_header_v_i = 1'b1;
      @(negedge clk_i);
      chk("t3_full_ready_low", HW'(mem_rsp_header_ready_and_o), HW'(0));
      chk("t3_full_v_low", HW'(mem_rsp_header_v_o), HW'(0));
      @(posedge clk_i); #1;
      mem_rsp_header_v_i = 1'b0;
      mem_rsp_release_i  = 1'b0;
      // A non-release header still passes while full.
      send_hdr(mk_hdr(20), 1'b0, 1'b0, '0, 1'b0);
      chk("t3_count_still_full", HW'(count_o), HW'(4));
      // Simultaneous yumi and release offer: blocked this cycle, taken next.
      offer_hdr(mk_hdr(21), 1'b0, 1'b1, addrs[4], 1'b1);
      yumi_drv = 1'b1;
      @(negedge clk_i);
      chk("t4_blocked_with_yumi", HW'(mem_rsp_header_ready_and_o), HW'(0));
      chk("t4_count_4", HW'(count_o), HW'(4));
      @(posedge clk_i); #1;
      yumi_drv = 1'b0;
      @(negedge clk_i);
      chk("t4_ready_next_cycle", HW'(mem_rsp_header_ready_and_o), HW'(1));
      chk("t4_count_3", HW'(count_o), HW'(3));
      @(posedge clk_i); #1;
      mem_rsp_header_v_i = 1'b0;
      mem_rsp_release_i  = 1'b0;
      chk("t4_count_back_4", HW'(count_o), HW'(4));
      // Drain across the pointer wrap; the monitor checks order.
      yumi_drv = 1'b1;
      repeat (4) @(posedge clk_i);
      #1;
      yumi_drv = 1'b0;
      chk("t4_drained", HW'(empty_o), HW'(1));
      chk("t4_rel_q_empty", HW'(rel_q.size()), HW'(0));

      // Reset mid-burst with two releases queued.
      send_hdr(mk_hdr(30), 1'b0, 1'b1, addrs[5], 1'b0);
      send_hdr(mk_hdr(31), 1'b0, 1'b1, addrs[0], 1'b1);
      send_hdr(mk_hdr(32), 1'b1, 1'b0, '0, 1'b0);
      send_beat(64'hAAAA_0000_0000_0001, 1'b0);
      data_q.push_back({1'b0, 64'hBBBB_0000_0000_0002});
      mem_rsp_data_i   = 64'hBBBB_0000_0000_0002;
      mem_rsp_data_v_i = 1'b1;
      @(negedge clk_i);
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("t5_data_v_o_async", HW'(mem_rsp_data_v_o), HW'(0));
      chk("t5_data_ready_async", HW'(mem_rsp_data_ready_and_o), HW'(0));
      chk("t5_pending_v_async", HW'(pending_w_v_o), HW'(0));
      chk("t5_count_async", HW'(count_o), HW'(0));
      chk("t5_empty_async", HW'(empty_o), HW'(1));
      mem_rsp_data_v_i = 1'b0;
      hdr_q.delete();
      data_q.delete();
      rel_q.delete();
      @(posedge clk_i); #1;
      reset_n_i = 1'b1;
      @(negedge clk_i);
      chk("t5_count_after", HW'(count_o), HW'(0));
      chk("t5_state_after", HW'(dbg_state_o), HW'(0));
      chk("t5_pending_after", HW'(pending_w_v_o), HW'(0));
      @(posedge clk_i); #1;

      // Back-to-back releases, yumi tied to valid.
      tie_en = 1'b1;
      base_pops = rel_pops;
      for (int i = 0; i < 6; i++) begin
         send_hdr(mk_hdr(40+i), 1'b0, 1'b1, addrs[5-i], 1'(i[0]));
         chk("t6_count_one", HW'(count_o), HW'(1));
      end
      @(posedge clk_i); #1;
      chk("t6_pops", HW'(rel_pops - base_pops), HW'(6));
      chk("t6_empty", HW'(empty_o), HW'(1));
      tie_en = 1'b0;

      repeat (3) @(posedge clk_i);
      #1;
      chk("end_hdr_q", HW'(hdr_q.size()), HW'(0));
      chk("end_data_q", HW'(data_q.size()), HW'(0));
      chk("end_rel_q", HW'(rel_q.size()), HW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bp_cce_hybrid_pending_release.md
Name: bp_cce_hybrid_pending_release

Overview:
- Sits on the memory-response path of the hybrid CCE, downstream of memory and upstream of the LCE command/response generator.
- Forwards BedRock burst memory responses (header plus optional data beats) unchanged.
- For every response header flagged as completing a coherent transaction, queues its address and drives a pending-bit decrement on the pending-bits write port. That port is the one the pending stage arbitrates with `pending_w_v_i`/`pending_w_yumi_o`.
- Together with the pending stage's increment-on-dispatch, this closes the pending-bit lifecycle.

Parameters:
- paddr_width_p, 40, physical address width.
- header_width_p, 128, packed memory response header width, treated as opaque.
- data_width_p, 64, data beat width.
- release_els_p, 4, depth of release address FIFO; power of 2, at least 2.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- mem_rsp_header_i  in  header_width_p  incoming response header
- mem_rsp_header_v_i  in  1  header valid
- mem_rsp_header_ready_and_o  out  1  header ready
- mem_rsp_has_data_i  in  1  header is followed by data beats
- mem_rsp_release_i  in  1  header requires pending decrement
- mem_rsp_addr_i  in  paddr_width_p  address to release (decoded from header)
- mem_rsp_bypass_hash_i  in  1  address bypasses way-group hash
- mem_rsp_data_i  in  data_width_p  data beat
- mem_rsp_data_v_i  in  1  data valid
- mem_rsp_data_ready_and_o  out  1  data ready
- mem_rsp_last_i  in  1  final beat
- mem_rsp_header_o, mem_rsp_header_v_o, mem_rsp_header_ready_and_i, mem_rsp_has_data_o  out/out/in/out  header_width_p/1/1/1  forwarded header stream
- mem_rsp_data_o, mem_rsp_data_v_o, mem_rsp_data_ready_and_i, mem_rsp_last_o  out/out/in/out  data_width_p/1/1/1  forwarded data stream
- pending_w_v_o  out  1  pending write request
- pending_w_yumi_i  in  1  write accepted this cycle
- pending_w_addr_o  out  paddr_width_p  write address
- pending_w_addr_bypass_hash_o  out  1  bypass hash
- pending_up_o, pending_down_o, pending_clear_o  out  1 each  write op
- empty_o  out  1  release FIFO empty
- count_o  out  $clog2(release_els_p+1)  FIFO occupancy

Behaviour:

Reset (reset_n_i low, asynchronous):
- state=e_ready, FIFO empty, count_o=0, empty_o=1.
- All valid/ready outputs 0.
- Release is synchronous to the clock edge following deassertion.
- A reset mid-burst discards the burst and all queued releases; no partial write is issued.

Stream FSM, states e_ready and e_data:
- e_ready:
  - header_v_o = header_v_i & ok, where ok = ~release_i | ~full.
  - header_ready_and_o = header_ready_and_i & ok.
  - header_o and has_data_o are forwarded combinationally; data outputs are 0.
  - On accept (v&ready):
    - if release_i, enqueue {addr_i, bypass_hash_i};
    - if has_data_i, go to e_data; otherwise stay.
- e_data:
  - Data is passed combinationally: data_v_o = data_v_i, data_ready_and_o = data_ready_and_i, last_o = last_i.
  - Header ready and header valid outputs are 0.
  - Go to e_ready on a beat with v & ready & last.

Full handling:
- full means count == release_els_p.
- Full blocks a release header even if a dequeue occurs in the same cycle (no bypass), which keeps the ready path independent of pending_w_yumi_i.
- Non-release headers pass while full.

Release port:
- pending_w_v_o = ~empty.
- addr_o and bypass_hash_o come from the FIFO head.
- down_o = ~empty; up_o = 0 and clear_o = 0 always.
- Dequeue when pending_w_yumi_i=1. yumi is only legal while v_o=1.
- Valid-then-yumi: v_o and the head address are stable until yumi.

Timing and ordering:
- A header accepted in cycle N produces pending_w_v_o in cycle N+1 at the earliest.
- Releases are issued in acceptance order.

Counter:
- Simultaneous enqueue and dequeue leaves count unchanged; read and write pointers both advance and wrap modulo release_els_p.

Assertions (simulation only):
- yumi without v.
- data_v_i in e_ready.

Test Plan:
- Reset, then one header with release=1, has_data=0, addr=0x8000_0040 -> header forwarded the same cycle; next cycle pending_w_v_o=1, addr=0x8000_0040, down=1, up=0; yumi -> empty_o=1.
- Header with has_data=1 plus 4 beats, downstream ready toggling every cycle -> all 4 beats forwarded in order, last_o on beat 4, FSM back to e_ready; no header accepted during the beats.
- 4 release headers with yumi held 0 -> count_o=4; 5th release header sees ready_and_o=0; a non-release header still passes; yumi once -> 5th accepted the next cycle.
- With count=4, simultaneous yumi and an offered release header -> header blocked that cycle and accepted the next; count goes 4→3→4; release order preserved across pointer wrap.
- Assert reset_n_i low mid-burst (beat 2 of 4) with 2 queued releases -> outputs 0 immediately without waiting for a clock; after release, count_o=0 and state=e_ready.
- Back-to-back release headers with yumi tied to v -> one pending down per cycle; addresses match input order exactly.
